phase_acc_mux: RTL and testbench
================================

Name: phase_acc_mux

Overview:
- Time-multiplexed phase generator, directly downstream of the per-operator phase-increment stage.
- On each sample_clk_en, sweeps all operator slots in order: requests the slot's phase_inc, adds it to that slot's stored phase accumulator, and emits the truncated phase to the waveform/operator stage.
- Handles key-on phase reset per slot.

Parameters:
- NUM_OPS, 18, number of operator slots swept per sample.
- ACC_WIDTH, 20, phase accumulator width; equals phase_inc width.
- OUT_WIDTH, 10, output phase width (top bits of accumulator).
- OP_WIDTH, 5, width of slot index (must satisfy 2^OP_WIDTH >= NUM_OPS).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- sample_clk_en  in  1  one-cycle pulse; starts a sweep
- op_req  out  OP_WIDTH  slot index whose phase_inc/key_on is requested
- phase_inc  in  ACC_WIDTH signed  increment for slot op_req from the previous cycle (1-cycle upstream latency)
- key_on  in  1  key-on state of the same slot as phase_inc, same timing
- phase_out  out  OUT_WIDTH  accumulator[ACC_WIDTH-1 -: OUT_WIDTH] after update
- phase_op  out  OP_WIDTH  slot index of phase_out
- phase_valid  out  1  phase_out/phase_op valid this cycle
- busy  out  1  sweep in progress
- overrun  out  1  one-cycle pulse: sample_clk_en arrived while busy

Behaviour:
- Reset values: op_req=0, phase_out=0, phase_op=0, phase_valid=0, busy=0, overrun=0. All NUM_OPS accumulators=0. All stored previous key_on bits=0. FSM=IDLE.
- FSM states:
  - IDLE: on sample_clk_en go to SWEEP, op_req=0, busy=1.
  - SWEEP: op_req increments by 1 each cycle. After issuing op_req=NUM_OPS-1, go to DRAIN.
  - DRAIN: holds op_req at NUM_OPS-1 until the last result is written, then goes to IDLE. busy=0 from the cycle phase_valid for slot NUM_OPS-1 is high.
- Pipeline, with T = cycle op_req=k issued:
  - T+1: phase_inc/key_on for slot k sampled. Accumulator k read, new value computed and written.
  - T+2: phase_out/phase_op=k/phase_valid=1 registered.
- Sweep latency: first phase_valid 2 cycles after op_req=0 issue. NUM_OPS consecutive valid cycles, slots in ascending order, no gaps.
- Accumulator update: acc_k <= acc_k + phase_inc (two's complement, modulo 2^ACC_WIDTH). Negative increments (vibrato) wrap downward; 0 - 1 -> 0xFFFFF.
- Key-on edge: if key_on=1 and stored prev_key_on_k=0, acc_k <= 0 (increment not added) and phase_out for k is 0. prev_key_on_k <= key_on every update of slot k.
- Key held on, or key off: normal accumulation; phase keeps running when key is off.
- sample_clk_en while busy (SWEEP or DRAIN): ignored, overrun=1 for one cycle, current sweep unaffected.
- sample_clk_en in the same cycle the FSM returns to IDLE: not accepted (busy still high), overrun asserted.
- rst mid-sweep: all state cleared next cycle. No further phase_valid. Accumulators zero.
- Only slots being updated are written; other slots hold.

Optional Feature:
- Macro PHASE_MOD_EN.
- When defined, adds input phase_mod (OUT_WIDTH, signed), sampled with phase_inc at T+1.
- phase_out = (acc_k top OUT_WIDTH bits + phase_mod) modulo 2^OUT_WIDTH, for FM modulation/feedback. The stored accumulator is never modified by phase_mod.
- Key-on edge outputs phase_mod alone.
- When undefined, the port does not exist and phase_out is the raw top bits.

Test Plan:
- Reset then one sweep, phase_inc=0x00400 all slots, key_on=0 -> 18 valid cycles, phase_op 0..17, phase_out=0x001 each; busy drops with slot 17 result.
- Ten sweeps, slot 3 phase_inc=0x00400 -> slot 3 phase_out 0x001,0x002,...,0x00A. Wrap: preload 1024 sweeps -> phase_out returns 0x000.
- Slot 5 phase_inc=0xFFFFF (-1) from zero -> accumulator 0xFFFFF, phase_out=0x3FF.
- Slot 2 accumulating at 0x10000/sweep, key_on 0->1 on sweep 4 -> that sweep phase_out=0; next sweep 0x040 with key_on held.
- sample_clk_en pulsed mid-sweep at slot 9 -> overrun=1 one cycle, sweep completes with 18 results, no second sweep.
- rst asserted at slot 7 -> phase_valid stops; next sweep, phase_inc=0x00400 -> all slots output 0x001 (with PHASE_MOD_EN, phase_mod=0x010 -> 0x011).

Source files
------------

// File: rtl/phase_acc_mux_if.sv
// Bus between the phase-increment stage, phase_acc_mux and the waveform stage.
// PHASE_MOD_EN adds the phase_mod input used for FM modulation/feedback.
interface phase_acc_mux_if #(
  parameter int ACC_WIDTH = 20,
  parameter int OUT_WIDTH = 10,
  parameter int OP_WIDTH  = 5
);
  logic                        sample_clk_en;
  logic [OP_WIDTH-1:0]         op_req;
  logic signed [ACC_WIDTH-1:0] phase_inc;
  logic                        key_on;
`ifdef PHASE_MOD_EN
  logic signed [OUT_WIDTH-1:0] phase_mod;
`endif
  logic [OUT_WIDTH-1:0]        phase_out;
  logic [OP_WIDTH-1:0]         phase_op;
  logic                        phase_valid;
  logic                        busy;
  logic                        overrun;

`ifdef PHASE_MOD_EN
  modport master (
    output sample_clk_en, phase_inc, key_on, phase_mod,
    input  op_req, phase_out, phase_op, phase_valid, busy, overrun
  );
  modport slave (
    input  sample_clk_en, phase_inc, key_on, phase_mod,
    output op_req, phase_out, phase_op, phase_valid, busy, overrun
  );
`else
  modport master (
    output sample_clk_en, phase_inc, key_on,
    input  op_req, phase_out, phase_op, phase_valid, busy, overrun
  );
  modport slave (
    input  sample_clk_en, phase_inc, key_on,
    output op_req, phase_out, phase_op, phase_valid, busy, overrun
  );
`endif
endinterface

// File: rtl/phase_acc_mux.sv
// Time-multiplexed per-slot phase accumulator with key-on phase reset.
// Optional PHASE_MOD_EN: adds phase_mod to the emitted phase (accumulator untouched).
module phase_acc_mux #(
  parameter int NUM_OPS   = 18,
  parameter int ACC_WIDTH = 20,
  parameter int OUT_WIDTH = 10,
  parameter int OP_WIDTH  = 5
) (
  input  logic            clk,
  input  logic            rst,
  phase_acc_mux_if.slave  bus
);
  localparam logic [OP_WIDTH-1:0] LAST_OP = OP_WIDTH'(NUM_OPS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [OP_WIDTH-1:0]   op_req_q, op_req_d;
  logic                  overrun_q, overrun_d;
  logic                  busy;

  logic                  s1_valid_q;
  logic [OP_WIDTH-1:0]   s1_op_q;

  logic [ACC_WIDTH-1:0]  acc_q [NUM_OPS];
  logic [NUM_OPS-1:0]    prev_key_q;
  logic [NUM_OPS-1:0]    wr_en;

  logic [ACC_WIDTH-1:0]  acc_rd;
  logic [ACC_WIDTH-1:0]  acc_new;
  logic                  key_edge;
  logic [OUT_WIDTH-1:0]  phase_d;

  logic [OUT_WIDTH-1:0]  phase_out_q;
  logic [OP_WIDTH-1:0]   phase_op_q;
  logic                  phase_valid_q;

  assign busy = (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    op_req_d  = op_req_q;
    overrun_d = bus.sample_clk_en && busy;
    case (state_q)
      ST_IDLE: begin
        if (bus.sample_clk_en) begin
          state_d  = ST_SWEEP;
          op_req_d = '0;
        end
      end
      ST_SWEEP: begin
        if (op_req_q == LAST_OP) begin
          state_d = ST_DRAIN;
        end else begin
          op_req_d = op_req_q + 1'b1;
        end
      end
      // The last slot is written in the single DRAIN cycle, so leave immediately.
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_req_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_req_q  <= op_req_d;
      overrun_q <= overrun_d;
    end
  end

  // Read-modify-write of the slot whose upstream data arrives this cycle.
  assign acc_rd   = acc_q[s1_op_q];
  assign key_edge = bus.key_on && !prev_key_q[s1_op_q];
  assign acc_new  = key_edge ? '0 : (acc_rd + $unsigned(bus.phase_inc));

`ifdef PHASE_MOD_EN
  assign phase_d = key_edge ? $unsigned(bus.phase_mod)
                            : (acc_new[ACC_WIDTH-1 -: OUT_WIDTH] + $unsigned(bus.phase_mod));
`else
  assign phase_d = acc_new[ACC_WIDTH-1 -: OUT_WIDTH];
`endif

  for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_wr_en
    assign wr_en[gi] = s1_valid_q && (s1_op_q == OP_WIDTH'(gi));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_OPS; i++) begin
        acc_q[i]      <= '0;
        prev_key_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_OPS; i++) begin
        if (wr_en[i]) begin
          acc_q[i]      <= acc_new;
          prev_key_q[i] <= bus.key_on;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_op_q       <= '0;
      phase_valid_q <= 1'b0;
      phase_out_q   <= '0;
      phase_op_q    <= '0;
    end else begin
      s1_valid_q    <= (state_q == ST_SWEEP);
      s1_op_q       <= op_req_q;
      phase_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        phase_out_q <= phase_d;
        phase_op_q  <= s1_op_q;
      end
    end
  end

  assign bus.op_req      = op_req_q;
  assign bus.phase_out   = phase_out_q;
  assign bus.phase_op    = phase_op_q;
  assign bus.phase_valid = phase_valid_q;
  assign bus.busy        = busy;
  assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_phase_acc_mux.sv
// Scoreboard bench for phase_acc_mux: per-sweep expectations from a plain arithmetic model.
module tb_phase_acc_mux;
  localparam int NUM_OPS   = 18;
  localparam int ACC_WIDTH = 20;
  localparam int OUT_WIDTH = 10;
  localparam int OP_WIDTH  = 5;
  localparam int ACC_MASK  = (1 << ACC_WIDTH) - 1;
  localparam int OUT_MASK  = (1 << OUT_WIDTH) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  phase_acc_mux_if #(.ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH), .OP_WIDTH(OP_WIDTH)) bus ();

  phase_acc_mux #(.NUM_OPS(NUM_OPS), .ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH), .OP_WIDTH(OP_WIDTH))
    dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {int op; int ph;} exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int inc_tab  [NUM_OPS];
  bit key_tab  [NUM_OPS];
  int mod_tab  [NUM_OPS];
  int m_acc    [NUM_OPS];
  bit m_prev   [NUM_OPS];
  int last_out [NUM_OPS];
  int n_valid = 0, n_ovr = 0, first_cyc = 0, last_cyc = 0, start_cyc = 0;
  int req_seen = 0;

  task automatic check(string name, int act, int expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Upstream stage: one cycle after seeing op_req it presents that slot's data.
  always @(negedge clk) req_seen = int'(bus.op_req);
  always @(posedge clk) begin
    #1;
    bus.phase_inc = ACC_WIDTH'(inc_tab[req_seen % NUM_OPS]);
    bus.key_on    = key_tab[req_seen % NUM_OPS];
`ifdef PHASE_MOD_EN
    bus.phase_mod = OUT_WIDTH'(mod_tab[req_seen % NUM_OPS]);
`endif
  end

  // Monitor: pops one expectation per valid output cycle.
  always @(negedge clk) begin
    exp_t e;
    if (bus.overrun) n_ovr++;
    if (bus.phase_valid) begin
      n_valid++;
      if (int'(bus.phase_op) == 0) first_cyc = cyc;
      if (int'(bus.phase_op) == NUM_OPS - 1) last_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_valid: phase_op=%0d phase_out=0x%0h, no result expected (cycle %0d)",
                 bus.phase_op, bus.phase_out, cyc);
      end else begin
        e = exp_q.pop_front();
        $display("txn slot=%0d phase_out=0x%03h expected=0x%03h", bus.phase_op, bus.phase_out, e.ph);
        check("phase_op", int'(bus.phase_op), e.op);
        check("phase_out", int'(bus.phase_out), e.ph);
        check("busy_at_valid", int'(bus.busy), (e.op != NUM_OPS - 1) ? 1 : 0);
        last_out[e.op] = int'(bus.phase_out);
      end
    end
  end

  // Reference model: one full sweep, applied to every slot in ascending order.
  function automatic void push_sweep();
    exp_t e;
    for (int k = 0; k < NUM_OPS; k++) begin
      int mod = 0;
`ifdef PHASE_MOD_EN
      mod = mod_tab[k];
`endif
      if (key_tab[k] && !m_prev[k]) begin
        m_acc[k] = 0;
        e.ph = mod & OUT_MASK;
      end else begin
        m_acc[k] = (m_acc[k] + inc_tab[k]) & ACC_MASK;
        e.ph = ((m_acc[k] >> (ACC_WIDTH - OUT_WIDTH)) + mod) & OUT_MASK;
      end
      m_prev[k] = key_tab[k];
      e.op = k;
      exp_q.push_back(e);
    end
  endfunction

  task automatic set_all(int inc, bit key, int mod);
    for (int k = 0; k < NUM_OPS; k++) begin
      inc_tab[k] = inc;
      key_tab[k] = key;
      mod_tab[k] = mod;
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int k = 0; k < NUM_OPS; k++) begin
      m_acc[k]  = 0;
      m_prev[k] = 1'b0;
    end
  endtask

  task automatic start_sweep();
    push_sweep();
    @(posedge clk); #1;
    bus.sample_clk_en = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    bus.sample_clk_en = 1'b0;
  endtask

  task automatic wait_done(string name);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (!bus.busy && exp_q.size() == 0 && !bus.phase_valid) return;
    end
    n_checks++;
    n_err++;
    $display("FAIL %s_timeout: busy=%0d pending=%0d, required idle with 0 pending", name, bus.busy, exp_q.size());
    exp_q.delete();
  endtask

  task automatic wait_op(int target, string name);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (int'(bus.op_req) == target) return;
    end
    n_checks++;
    n_err++;
    $display("FAIL %s_timeout: op_req=%0d never reached %0d", name, bus.op_req, target);
  endtask

  task automatic sweep();
    start_sweep();
    wait_done("sweep");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.sample_clk_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clear_model();
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int n0, o0;
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, o0;
    bus.sample_clk_en = 1'b0;
    bus.phase_inc     = '0;
    bus.key_on        = 1'b0;
`ifdef PHASE_MOD_EN
    bus.phase_mod     = '0;
`endif
    set_all(0, 1'b0, 0);
    clear_model();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_op_req", int'(bus.op_req), 0);
    check("rst_phase_out", int'(bus.phase_out), 0);
    check("rst_phase_op", int'(bus.phase_op), 0);
    check("rst_phase_valid", int'(bus.phase_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_overrun", int'(bus.overrun), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // One sweep at 0x400 per slot
    set_all('h00400, 1'b0, 0);
    n0 = n_valid;
    sweep();
    check("sweep_count", n_valid - n0, NUM_OPS);
    check("first_latency", first_cyc - start_cyc, 3);
    check("no_gaps", last_cyc - first_cyc, NUM_OPS - 1);
    for (int k = 0; k < NUM_OPS; k++) check("basic_out", last_out[k], 'h001);

    // Slot 3 counts 1..10 then wraps after 1024 sweeps; other slots random
    do_reset();
    for (int s = 1; s <= 1024; s++) begin
      for (int k = 0; k < NUM_OPS; k++) begin
        inc_tab[k] = int'($urandom_range(0, ACC_MASK));
        key_tab[k] = ($urandom_range(0, 3) == 0);
        mod_tab[k] = int'($urandom_range(0, OUT_MASK));
      end
      inc_tab[3] = 'h00400;
      key_tab[3] = 1'b0;
      mod_tab[3] = 0;
      sweep();
      if (s <= 10) check("slot3_ramp", last_out[3], s);
    end
    check("slot3_wrap", last_out[3], 'h000);

    // Negative increment wraps downward
    do_reset();
    set_all(0, 1'b0, 0);
    inc_tab[5] = 'hFFFFF;
    sweep();
    check("neg_inc_slot5", last_out[5], 'h3FF);
    check("neg_inc_slot4", last_out[4], 'h000);

    // Key-on edge resets slot 2
    do_reset();
    set_all(0, 1'b0, 0);
    inc_tab[2] = 'h10000;
    repeat (3) sweep();
    check("slot2_before_keyon", last_out[2], 'h0C0);
    key_tab[2] = 1'b1;
    sweep();
    check("slot2_keyon_edge", last_out[2], 'h000);
    sweep();
    check("slot2_key_held", last_out[2], 'h040);

    // Overrun mid-sweep at slot 9
    set_all('h00400, 1'b0, 0);
    n0 = n_valid;
    o0 = n_ovr;
    start_sweep();
    wait_op(9, "op9");
    bus.sample_clk_en = 1'b1;
    @(posedge clk); #1;
    bus.sample_clk_en = 1'b0;
    check("overrun_pulse", int'(bus.overrun), 1);
    @(posedge clk); #1;
    check("overrun_one_cycle", int'(bus.overrun), 0);
    wait_done("overrun_sweep");
    repeat (30) @(posedge clk);
    #1;
    check("overrun_results", n_valid - n0, NUM_OPS);
    check("overrun_count", n_ovr - o0, 1);
    check("overrun_idle", int'(bus.busy), 0);

    // Request in the final busy cycle is rejected
    n0 = n_valid;
    start_sweep();
    wait_op(NUM_OPS - 1, "op_last");
    @(posedge clk); #1;
    bus.sample_clk_en = 1'b1;
    @(posedge clk); #1;
    bus.sample_clk_en = 1'b0;
    check("drain_overrun", int'(bus.overrun), 1);
    wait_done("drain_sweep");
    repeat (30) @(posedge clk);
    #1;
    check("drain_results", n_valid - n0, NUM_OPS);
    check("drain_idle", int'(bus.busy), 0);

    // Reset mid-sweep at slot 7
    start_sweep();
    wait_op(7, "op7");
    rst = 1'b1;
    @(posedge clk); #1;
    clear_model();
    check("midrst_valid", int'(bus.phase_valid), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_op_req", int'(bus.op_req), 0);
    rst = 1'b0;
    n0 = n_valid;
    repeat (20) @(posedge clk);
    #1;
    check("midrst_no_valid", n_valid - n0, 0);
    set_all('h00400, 1'b0, 'h010);
    sweep();
`ifdef PHASE_MOD_EN
    for (int k = 0; k < NUM_OPS; k++) check("post_rst_out", last_out[k], 'h011);
`else
    for (int k = 0; k < NUM_OPS; k++) check("post_rst_out", last_out[k], 'h001);
`endif

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
